// File: rtl/int_mac_pkg.sv
// Shared definitions for the integer MAC processing element and its feeder.
package int_mac_pkg;

    localparam int DEF_BITWIDTH = 32;
    localparam int DEF_PE_DELAY = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/int_mac_feeder.sv
// Streams len operand pairs from the A/B buffers into one MAC PE and
// captures the PE's dot-product result (or times out waiting for it).
module int_mac_feeder
    import int_mac_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int ADDR_W   = 4,
    parameter int PE_DELAY = DEF_PE_DELAY,
    parameter int TIMEOUT  = PE_DELAY + 4
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                start,
    input  logic [ADDR_W:0]     len,
    output logic                busy,
    output logic                done,
    output logic [BITWIDTH-1:0] result,
    output logic                err,
    output logic                buf_rd_en,
    output logic [ADDR_W-1:0]   buf_addr,
    input  logic [BITWIDTH-1:0] a_rdata,
    input  logic [BITWIDTH-1:0] b_rdata,
    output logic                pe_rstn,
    output logic [BITWIDTH-1:0] pe_ain,
    output logic [BITWIDTH-1:0] pe_bin,
    output logic                pe_valid,
    input  logic [BITWIDTH-1:0] pe_dout,
    input  logic                pe_dvalid
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    feeder_state_t    state;
    logic [ADDR_W:0]  len_q;
    logic [TMO_W-1:0] tmo;
    logic [ADDR_W:0]  next_cnt;

    // Extended by one bit so a full 2^ADDR_W job ends on the top address
    // instead of wrapping back to 0.
    assign next_cnt = {1'b0, buf_addr} + 1'b1;

    assign pe_rstn = aresetn & (state != CLEAR);

    // Buffer read data arrives exactly in the pe_valid cycle, so the operand
    // stage is the registered strobe gating the buffer outputs.
    assign pe_ain = pe_valid ? a_rdata : '0;
    assign pe_bin = pe_valid ? b_rdata : '0;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            result    <= '0;
            buf_rd_en <= 1'b0;
            buf_addr  <= '0;
            pe_valid  <= 1'b0;
            len_q     <= '0;
            tmo       <= '0;
        end else begin
            done     <= 1'b0;
            pe_valid <= buf_rd_en;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        result <= '0;
                        err    <= 1'b0;
                        len_q  <= len;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= CLEAR;
                            buf_rd_en <= 1'b1;
                            buf_addr  <= '0;
                        end
                    end
                end
                CLEAR, RUN: begin
                    if (buf_rd_en) begin
                        if (next_cnt == len_q) buf_rd_en <= 1'b0;
                        else                   buf_addr  <= buf_addr + 1'b1;
                    end
                    // Reads are gap-free, so a valid beat with no read behind
                    // it is the last pair.
                    if (state == CLEAR) begin
                        state <= RUN;
                    end else if (pe_valid && !buf_rd_en) begin
                        state <= DRAIN;
                        tmo   <= TMO_W'(TIMEOUT);
                    end
                end
                DRAIN: begin
                    if (pe_dvalid) begin
                        result <= pe_dout;
                        state  <= DONE;
                        done   <= 1'b1;
                    end else if (tmo == TMO_W'(1)) begin
                        err   <= 1'b1;
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        tmo <= tmo - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_mac_feeder.sv
// Directed bench for int_mac_feeder with a behavioural MAC PE, operand
// buffers and a result scoreboard.
module tb_int_mac_feeder;

    localparam int BW       = 32;
    localparam int AW       = 4;
    localparam int PE_DELAY = 4;
    localparam int TIMEOUT  = PE_DELAY + 4;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          start;
    logic [AW:0]   len;
    logic          busy, done, err;
    logic [BW-1:0] result;
    logic          buf_rd_en;
    logic [AW-1:0] buf_addr;
    logic [BW-1:0] a_rdata, b_rdata;
    logic          pe_rstn;
    logic [BW-1:0] pe_ain, pe_bin;
    logic          pe_valid;
    logic [BW-1:0] pe_dout;
    logic          pe_dvalid;

    int npass = 0;
    int ntot  = 0;

    typedef struct {
        logic [BW-1:0] res;
        logic          err;
        int            lat;
    } exp_t;
    exp_t sb[$];

    logic [BW-1:0] a_mem [16];
    logic [BW-1:0] b_mem [16];
    logic [BW-1:0] acc;
    logic [3:0]    dcnt;
    logic          pe_hang;

    int_mac_feeder #(.BITWIDTH(BW), .ADDR_W(AW), .PE_DELAY(PE_DELAY), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .aresetn(aresetn), .start(start), .len(len),
        .busy(busy), .done(done), .result(result), .err(err),
        .buf_rd_en(buf_rd_en), .buf_addr(buf_addr),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .pe_rstn(pe_rstn), .pe_ain(pe_ain), .pe_bin(pe_bin), .pe_valid(pe_valid),
        .pe_dout(pe_dout), .pe_dvalid(pe_dvalid)
    );

    always #5 clk = ~clk;

    // Operand buffers with one-cycle read latency.
    always @(posedge clk) begin
        if (buf_rd_en) begin
            a_rdata <= a_mem[buf_addr];
            b_rdata <= b_mem[buf_addr];
        end
    end

    // MAC PE: result strobe PE_DELAY edges after the last valid beat is sampled.
    always @(posedge clk or negedge pe_rstn) begin
        if (!pe_rstn) begin
            acc       <= '0;
            dcnt      <= '0;
            pe_dvalid <= 1'b0;
        end else begin
            pe_dvalid <= 1'b0;
            if (pe_valid) begin
                acc  <= acc + pe_ain * pe_bin;
                dcnt <= 4'(PE_DELAY);
            end else if (dcnt != 0) begin
                dcnt <= dcnt - 1'b1;
                if (dcnt == 1 && !pe_hang) pe_dvalid <= 1'b1;
            end
        end
    end
    assign pe_dout = acc;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Entered at a negedge of an idle cycle; returns at the negedge of the
    // cycle following done, where a new start is already legal.
    task automatic run_job(input string tag, input int n, input logic [BW-1:0] exp_res,
                           input logic exp_err, input int exp_lat, input bit poke);
        exp_t e;
        int c = 0, vcnt = 0, vfirst = 0, rcnt = 0, rlow = 0;
        bit gate_bad = 0, addr_bad = 0, got = 0, busy_bad = 0;
        int maxaddr = 0;
        sb.push_back('{exp_res, exp_err, exp_lat});
        len = (AW+1)'(n);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (c < 200) begin
            @(negedge clk);
            c++;
            if (poke) start = (c == 3);
            if (!busy) busy_bad = 1;
            if (pe_valid) begin
                vcnt++;
                if (vfirst == 0) vfirst = c;
            end else if (pe_ain !== '0 || pe_bin !== '0) gate_bad = 1;
            if (buf_rd_en) begin
                rcnt++;
                if (int'(buf_addr) != c - 1) addr_bad = 1;
                if (int'(buf_addr) > maxaddr) maxaddr = int'(buf_addr);
            end
            if (!pe_rstn) rlow++;
            if (done) begin got = 1; break; end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        e = sb.pop_front();
        chk({tag, "_result"},  64'(result), 64'(e.res));
        chk({tag, "_err"},     64'(err),    64'(e.err));
        chk({tag, "_latency"}, 64'(c),      64'(e.lat));
        chk({tag, "_valid_beats"}, 64'(vcnt), 64'(n));
        chk({tag, "_valid_first"}, 64'(vfirst), 64'(n > 0 ? 2 : 0));
        chk({tag, "_reads"}, 64'(rcnt), 64'(n));
        chk({tag, "_pe_rst_cycles"}, 64'(rlow), 64'(n > 0 ? 1 : 0));
        chk({tag, "_operand_gate"}, 64'(gate_bad), 64'd0);
        chk({tag, "_addr_seq"}, 64'(addr_bad), 64'd0);
        chk({tag, "_busy_held"}, 64'(busy_bad), 64'd0);
        if (n > 0) chk({tag, "_last_addr"}, 64'(maxaddr), 64'(n - 1));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit seen_done;
        aresetn = 1'b0;
        start   = 1'b0;
        len     = '0;
        pe_hang = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_mem[i] = BW'(i + 1);
            b_mem[i] = BW'(i + 5);
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_rd_en", 64'(buf_rd_en), 64'd0);
        chk("rst_addr", 64'(buf_addr), 64'd0);
        chk("rst_pe_valid", 64'(pe_valid), 64'd0);
        chk("rst_pe_ain", 64'(pe_ain), 64'd0);
        chk("rst_pe_rstn", 64'(pe_rstn), 64'd0);
        aresetn = 1'b1;
        @(negedge clk);

        // 1*5+2*6+3*7+4*8 = 70
        run_job("dot4", 4, 32'd70, 1'b0, 4 + PE_DELAY + 3, 1'b0);
        a_mem[0] = 3; a_mem[1] = 3; b_mem[0] = 3; b_mem[1] = 3;
        run_job("b2b", 2, 32'd18, 1'b0, 2 + PE_DELAY + 3, 1'b0);
        run_job("len0", 0, 32'd0, 1'b0, 1, 1'b0);
        a_mem[0] = 32'hFFFF_FFFF; b_mem[0] = 32'd2;
        run_job("ovf", 1, 32'hFFFF_FFFE, 1'b0, 1 + PE_DELAY + 3, 1'b0);

        // Full-length job: sum of 1..16 with B all ones = 136.
        for (int i = 0; i < 16; i++) begin a_mem[i] = BW'(i + 1); b_mem[i] = 1; end
        run_job("max16", 16, 32'd136, 1'b0, 16 + PE_DELAY + 3, 1'b0);

        pe_hang = 1'b1;
        run_job("tmo", 3, 32'd0, 1'b1, 3 + 2 + TIMEOUT, 1'b1);
        pe_hang = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy || done) seen_done = 1;
        end
        chk("tmo_start_ignored", 64'(seen_done), 64'd0);

        // Reset in the middle of an 8-pair job.
        len = 5'd8;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_in_run", 64'(pe_valid), 64'd1);
        #1 aresetn = 1'b0;
        #1;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_rd_en", 64'(buf_rd_en), 64'd0);
        chk("mid_addr", 64'(buf_addr), 64'd0);
        chk("mid_pe_valid", 64'(pe_valid), 64'd0);
        chk("mid_pe_ain", 64'(pe_ain), 64'd0);
        chk("mid_pe_rstn", 64'(pe_rstn), 64'd0);
        chk("mid_result", 64'(result), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        chk("mid_no_done", 64'(seen_done), 64'd0);
        for (int i = 0; i < 16; i++) begin
            a_mem[i] = BW'(i + 1);
            b_mem[i] = BW'(i + 5);
        end
        run_job("after_rst", 4, 32'd70, 1'b0, 4 + PE_DELAY + 3, 1'b0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
